// File: rtl/dmux_1t2_32_pkg.sv
// Shared definitions for the 1-to-2 registered demultiplexer.
//   WIDTH_DEF    : default data width
//   chan_state_e : per-channel occupancy encoding (EMPTY/ONE/TWO)
//   CH0, CH1     : channel index constants used for in_sel decoding
package dmux_1t2_32_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } chan_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // A channel can take another word unless both entries are occupied.
    function automatic logic chan_has_room(input chan_state_e st);
        return st != TWO;
    endfunction

endpackage

// File: rtl/dmux_1t2_32_chan_fifo2.sv
// Two-entry registered FIFO for one demux channel.
//   clk, rst     : clock, synchronous active-high reset
//   push         : write push_data this cycle (never asserted while TWO)
//   push_data    : word to enqueue
//   out_ready    : consumer takes the head word when out_valid is high
//   out_valid    : at least one word is held
//   out_data     : registered head word
//   state        : current occupancy, used upstream for in_ready
module dmux_1t2_32_chan_fifo2
    import dmux_1t2_32_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output chan_state_e      state
);

    chan_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] tail_q,  tail_d;
    logic             valid_q, valid_d;
    logic             pop;

    // Pop only counts when a word is actually presented.
    assign pop = valid_q & out_ready;

    // Next-state and entry update.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({push, pop})
                    2'b10: begin
                        tail_d  = push_data;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    // Head leaves as the new word arrives; it becomes head.
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        valid_d = (state_d != EMPTY);
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;
    assign state     = state_q;

endmodule

// File: rtl/dmux_1t2_32.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream to one of
// two independently buffered destinations.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid, in_ready, in_data    : source handshake and word
//   in_sel                         : destination (CH0 -> out0, CH1 -> out1)
//   outK_valid, outK_ready, outK_data : per-destination handshake and head word
module dmux_1t2_32
    import dmux_1t2_32_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);

    chan_state_e st0, st1;
    logic        accept;
    logic        push0, push1;

    // in_ready follows the selected channel's registered occupancy only;
    // held high in reset since any word offered then is dropped anyway.
    assign in_ready = rst | chan_has_room((in_sel == CH1) ? st1 : st0);

    assign accept = in_valid & in_ready;
    assign push0  = accept & (in_sel == CH0);
    assign push1  = accept & (in_sel == CH1);

    dmux_1t2_32_chan_fifo2 #(.WIDTH(WIDTH)) u_chan0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .out_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .state     (st0)
    );

    dmux_1t2_32_chan_fifo2 #(.WIDTH(WIDTH)) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .out_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .state     (st1)
    );

endmodule
